fetch_exec_sequencer: RTL and testbench



---
 rtl/fetch_exec_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fetch_exec_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_sequencer.sv
// Control-step sequencer for the bus-based datapath: fetch, decode and execute of
// three-register ALU ops and MUL/DIV, with memory-ready timeout, NOP/HALT and fault handling.
module fetch_exec_sequencer #(
    parameter int unsigned           DATA_W      = 32,
    parameter int unsigned           OPCODE_W    = 5,
    parameter logic [OPCODE_W-1:0]   OP_ALU_MAX  = 5'h0C,
    parameter logic [OPCODE_W-1:0]   OP_MUL      = 5'h0F,
    parameter logic [OPCODE_W-1:0]   OP_DIV      = 5'h10,
    parameter logic [OPCODE_W-1:0]   OP_NOP      = 5'h1A,
    parameter logic [OPCODE_W-1:0]   OP_HALT     = 5'h1B,
    parameter int unsigned           MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic                MemReady,
    input  logic [DATA_W-1:0]   IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [OPCODE_W-1:0] alu_op,
    output logic [3:0]          step,
    output logic                Done,
    output logic                Halted,
    output logic                Fault,
    output logic [DATA_W-1:0]   instr_count
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8,
        S_FAULT = 4'd9
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   count_q;
    logic [OPCODE_W-1:0] opcode;
    logic                is_alu, is_muldiv;
    logic                unused_ir_bits;

    assign opcode         = IR[DATA_W-1 -: OPCODE_W];
    assign is_alu         = (opcode <= OP_ALU_MAX);
    assign is_muldiv      = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign unused_ir_bits = ^IR[DATA_W-OPCODE_W-1:0];

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (Done)
                count_q <= count_q + DATA_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
        ZLOout = 1'b0; ZHIout = 1'b0; PCin = 1'b0; Read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        alu_op = '0;
        Done   = 1'b0;
        Halted = 1'b0;
        Fault  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Run)
                    state_d = S_T0;
            end
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                wait_d  = '0;
                state_d = S_T1;
            end
            S_T1: begin
                ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (MemReady) begin
                    wait_d  = '0;
                    state_d = S_T2;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu || is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_d = S_T4;
                end else if (opcode == OP_NOP) begin
                    Done    = 1'b1;
                    state_d = Run ? S_T0 : S_IDLE;
                end else if (opcode == OP_HALT) begin
                    Done    = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_T4: begin
                Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                alu_op  = opcode;
                state_d = S_T5;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    Done    = 1'b1;
                    state_d = Run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                ZHIout = 1'b1; HIin = 1'b1;
                Done    = 1'b1;
                state_d = Run ? S_T0 : S_IDLE;
            end
            S_HALT:  Halted = 1'b1;
            S_FAULT: Fault  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // The retiring cycle already shows the incremented count; the register catches up at the edge.
    always_comb begin
        instr_count = count_q + (Done ? DATA_W'(1) : '0);
        step        = state_q;
    end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench for fetch_exec_sequencer: directed scenarios plus a randomized
// instruction stream checked against a per-instruction timeline model.
module tb_fetch_exec_sequencer;

    logic        clk = 1'b0;
    logic        Clear, Run, MemReady;
    logic [31:0] IR;
    logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic [3:0]  step;
    logic        Done, Halted, Fault;
    logic [31:0] instr_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned exp_count   = 0;

    localparam int CLS_ALU = 0, CLS_MD = 1, CLS_NOP = 2, CLS_HALT = 3, CLS_ILL = 4;

    fetch_exec_sequencer #(.DATA_W(32), .OPCODE_W(5), .MEM_TIMEOUT(15)) dut (
        .Clock(clk), .Clear(Clear), .Run(Run), .MemReady(MemReady), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLOout(ZLOout),
        .ZHIout(ZHIout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .step(step), .Done(Done),
        .Halted(Halted), .Fault(Fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [18:0] ctrl;
    assign ctrl = {Rout, Rin, Grc, Grb, Gra, LOin, HIin, Yin, IRin, MDRout, MDRin,
                   Read, PCin, ZHIout, ZLOout, Zin, IncPC, MARin, PCout};

    function automatic logic [18:0] bit_of(input int n);
        return 19'(1) << n;
    endfunction

    function automatic int cls_of(input logic [4:0] op);
        if (op <= 5'h0C) return CLS_ALU;
        if (op == 5'h0F || op == 5'h10) return CLS_MD;
        if (op == 5'h1A) return CLS_NOP;
        if (op == 5'h1B) return CLS_HALT;
        return CLS_ILL;
    endfunction

    // Expected control set for a given step of an instruction of a given class.
    function automatic logic [18:0] exp_ctrl(input int st, input int cls);
        case (st)
            1: return bit_of(0) | bit_of(1) | bit_of(2) | bit_of(3);
            2: return bit_of(4) | bit_of(6) | bit_of(7) | bit_of(8);
            3: return bit_of(9) | bit_of(10);
            4: return (cls == CLS_ALU || cls == CLS_MD) ? (bit_of(15) | bit_of(18) | bit_of(11)) : '0;
            5: return bit_of(16) | bit_of(18) | bit_of(3);
            6: return (cls == CLS_MD) ? (bit_of(4) | bit_of(13)) : (bit_of(4) | bit_of(14) | bit_of(17));
            7: return bit_of(5) | bit_of(12);
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int cycles);
        Clear = 1'b1; Run = 1'b0; MemReady = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        Clear = 1'b0;
        exp_count = 0;
    endtask

    task automatic start_from_idle();
        Run = 1'b1;
        tick();
    endtask

    // Precondition: sampled in T0. Returns sampled in T0 of the next instruction,
    // or in HALT/FAULT for those outcomes.
    task automatic run_instr(input logic [31:0] ir, input int w, input bit run_after);
        int          cls, lat, st;
        bit          retires, last;
        logic [31:0] cnt_exp;
        logic [4:0]  op_exp;
        IR      = ir;
        cls     = cls_of(ir[31:27]);
        lat     = (cls == CLS_ALU) ? 6 + w : (cls == CLS_MD) ? 7 + w : 4 + w;
        retires = (cls != CLS_ILL);
        for (int k = 0; k < lat; k++) begin
            last    = (k == lat - 1);
            st      = (k == 0) ? 1 : (k <= 1 + w) ? 2 : k - w + 1;
            cnt_exp = exp_count + ((last && retires) ? 1 : 0);
            op_exp  = (st == 5) ? ir[31:27] : 5'h00;
            vectors++;
            if (step !== 4'(st)) begin
                miscompares++;
                $display("FAIL step op=%h k=%0d: got %0d expected %0d", ir[31:27], k, step, st);
            end
            vectors++;
            if (ctrl !== exp_ctrl(st, cls)) begin
                miscompares++;
                $display("FAIL ctrl op=%h k=%0d: got %h expected %h", ir[31:27], k, ctrl, exp_ctrl(st, cls));
            end
            vectors++;
            if (alu_op !== op_exp || Done !== (last && retires) || instr_count !== cnt_exp) begin
                miscompares++;
                $display("FAIL alu_op/done/count op=%h k=%0d: got %h/%b/%0d expected %h/%b/%0d",
                         ir[31:27], k, alu_op, Done, instr_count, op_exp, last && retires, cnt_exp);
            end
            MemReady = (k >= 1 + w);
            Run      = last ? run_after : 1'($urandom);
            tick();
        end
        if (retires) exp_count++;
        if (cls == CLS_HALT || cls == CLS_ILL) begin
            st = (cls == CLS_HALT) ? 8 : 9;
            vectors++;
            if (step !== 4'(st) || Halted !== (cls == CLS_HALT) || Fault !== (cls == CLS_ILL)
                || ctrl !== '0 || Done !== 1'b0 || instr_count !== exp_count) begin
                miscompares++;
                $display("FAIL terminal op=%h: got step=%0d H=%b F=%b ctrl=%h done=%b cnt=%0d expected step=%0d cnt=%0d",
                         ir[31:27], step, Halted, Fault, ctrl, Done, instr_count, st, exp_count);
            end
        end else if (!run_after) begin
            vectors++;
            if (step !== 4'd0 || ctrl !== '0 || Done !== 1'b0 || instr_count !== exp_count) begin
                miscompares++;
                $display("FAIL idle_after op=%h: got step=%0d ctrl=%h done=%b cnt=%0d expected 0/0/0/%0d",
                         ir[31:27], step, ctrl, Done, instr_count, exp_count);
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
            start_from_idle();
        end
    endtask

    task automatic test_reset();
        do_clear(2);
        vectors++;
        if (step !== 4'd0 || ctrl !== '0 || alu_op !== 5'h0 || Done !== 1'b0 || Halted !== 1'b0
            || Fault !== 1'b0 || instr_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: got step=%0d ctrl=%h alu=%h D=%b H=%b F=%b cnt=%0d expected all zero",
                     step, ctrl, alu_op, Done, Halted, Fault, instr_count);
        end
        tick();
        vectors++;
        if (step !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_hold: got step=%0d expected 0", step);
        end
    endtask

    task automatic test_div();
        start_from_idle();
        run_instr(32'h80918000, 0, 1'b1);
    endtask

    task automatic test_alu_wait();
        run_instr(32'h00918000, 3, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: op = 5'($urandom_range(0, 12));
                1: op = 5'h0F;
                2: op = 5'h10;
                default: op = 5'h1A;
            endcase
            run_instr({op, 27'($urandom)}, int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    task automatic test_clear_mid_t4();
        IR = 32'h08918000; MemReady = 1'b1; Run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (step !== 4'd5) begin
            miscompares++;
            $display("FAIL reach_t4: got step=%0d expected 5", step);
        end
        vectors++;
        if (instr_count === 32'd0) begin
            miscompares++;
            $display("FAIL count_before_clear: got %0d expected nonzero", instr_count);
        end
        do_clear(2);
        vectors++;
        if (step !== 4'd0 || ctrl !== '0 || alu_op !== 5'h0 || instr_count !== 32'd0
            || Fault !== 1'b0 || Done !== 1'b0 || Halted !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_mid_t4: got step=%0d ctrl=%h alu=%h cnt=%0d F=%b D=%b H=%b expected all zero",
                     step, ctrl, alu_op, instr_count, Fault, Done, Halted);
        end
    endtask

    task automatic test_nop_halt();
        start_from_idle();
        run_instr({5'h1A, 27'($urandom)}, int'($urandom_range(0, 2)), 1'b1);
        run_instr({5'h1B, 27'($urandom)}, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            Run = 1'(i);
            tick();
            vectors++;
            if (step !== 4'd8 || Halted !== 1'b1 || ctrl !== '0 || instr_count !== 32'd2) begin
                miscompares++;
                $display("FAIL halt_hold i=%0d: got step=%0d H=%b ctrl=%h cnt=%0d expected 8/1/0/2",
                         i, step, Halted, ctrl, instr_count);
            end
        end
        do_clear(1);
    endtask

    task automatic test_illegal();
        start_from_idle();
        run_instr({5'h14, 27'($urandom)}, 1, 1'b1);
        do_clear(1);
    endtask

    task automatic test_timeout();
        start_from_idle();
        IR = 32'h00918000; MemReady = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            Run = 1'($urandom);
            vectors++;
            if (step !== 4'd2 || Read !== 1'b1 || MDRin !== 1'b1 || Fault !== 1'b0) begin
                miscompares++;
                $display("FAIL t1_wait i=%0d: got step=%0d Read=%b MDRin=%b F=%b expected 2/1/1/0",
                         i, step, Read, MDRin, Fault);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (step !== 4'd9 || Fault !== 1'b1 || ctrl !== '0 || Done !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout i=%0d: got step=%0d F=%b ctrl=%h D=%b expected 9/1/0/0",
                         i, step, Fault, ctrl, Done);
            end
            Run = 1'(i); MemReady = 1'(i);
            tick();
        end
        do_clear(1);
    endtask

    initial begin
        Clear = 1'b1; Run = 1'b0; MemReady = 1'b0; IR = '0;
        tick();
        test_reset();
        test_div();
        test_alu_wait();
        test_random();
        test_clear_mid_t4();
        test_nop_halt();
        test_illegal();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
